seed_add32_seq: RTL and testbench

//  Sequencer that time-shares one external 8-bit ripple adder (A,B,c_in -> Sum,c_out) to do

---
 rtl/seed_add32_seq.sv | 166 ++++++++++++++++
 tb/tb_seed_add32_seq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seed_add32_seq.sv
// seed_add32_seq -- byte-serial modular adder/subtractor sequencer for the SEED datapath.
// Time-shares one external 8-bit ripple adder: one operand byte per clock, LSB first,
// with the carry chained through an internal register between bytes.
// Optional feature macro: SEED_ADDSEQ_SUB_EN
//   defined   -> op_sub selects subtract (B bytes inverted, carry-in 1 on byte 0)
//   undefined -> add only; op_sub is accepted on the port but has no effect
module seed_add32_seq #(
   parameter int WORD_BYTES = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      op_sub,
   input  logic [8*WORD_BYTES-1:0]   a_in,
   input  logic [8*WORD_BYTES-1:0]   b_in,
   output logic                      busy,
   output logic                      done,
   output logic [8*WORD_BYTES-1:0]   result,
   output logic                      carry_out,
   output logic [7:0]                add_a,
   output logic [7:0]                add_b,
   output logic                      add_cin,
   input  logic [7:0]                add_sum,
   input  logic                      add_cout
);

   localparam int W  = 8 * WORD_BYTES;
   localparam int CW = $clog2(WORD_BYTES);
   localparam logic [CW-1:0] LAST_BYTE = CW'(WORD_BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    result_q, result_d;
   logic            carry_out_q, carry_out_d;

   // Latched operands split into byte lanes so the active lane is a plain array select.
   logic [7:0]      a_byte [WORD_BYTES];
   logic [7:0]      b_byte [WORD_BYTES];
   logic [7:0]      b_lane;
   logic            init_carry;

   for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign a_byte[gi] = a_q[8*gi +: 8];
      assign b_byte[gi] = b_q[8*gi +: 8];
   end

`ifdef SEED_ADDSEQ_SUB_EN
   // Operation mode is frozen at accept so a changing op_sub cannot corrupt a running op.
   logic sub_q, sub_d;

   // Subtract is a + ~b + 1: invert the B lane and seed the carry chain with 1.
   assign b_lane     = sub_q ? ~b_byte[byte_cnt_q] : b_byte[byte_cnt_q];
   assign init_carry = op_sub;

   // Mode register, cleared on reset, loaded only when a request is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         sub_q <= 1'b0;
      end else begin
         sub_q <= sub_d;
      end
   end

   // Capture op_sub on the accepting edge, hold otherwise.
   always_comb begin
      sub_d = sub_q;
      if (state_q == ST_IDLE && start) begin
         sub_d = op_sub;
      end
   end
`else
   // Add-only build: op_sub is kept on the port for drop-in compatibility but unused.
   logic unused_op_sub;
   assign unused_op_sub = op_sub;

   assign b_lane     = b_byte[byte_cnt_q];
   assign init_carry = 1'b0;
`endif

   // State, operand, counter, carry and result registers; reset returns everything to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         byte_cnt_q  <= '0;
         carry_q     <= 1'b0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         byte_cnt_q  <= byte_cnt_d;
         carry_q     <= carry_d;
         result_q    <= result_d;
         carry_out_q <= carry_out_d;
      end
   end

   // Next-state logic and adder drive: adder inputs are only non-zero while a byte is in flight.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      byte_cnt_d  = byte_cnt_q;
      carry_d     = carry_q;
      result_d    = result_q;
      carry_out_d = carry_out_q;
      add_a       = 8'h00;
      add_b       = 8'h00;
      add_cin     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d        = a_in;
               b_d        = b_in;
               byte_cnt_d = '0;
               carry_d    = init_carry;
               state_d    = ST_RUN;
            end
         end

         ST_RUN: begin
            add_a   = a_byte[byte_cnt_q];
            add_b   = b_lane;
            add_cin = carry_q;
            result_d[8*byte_cnt_q +: 8] = add_sum;
            carry_d = add_cout;
            if (byte_cnt_q == LAST_BYTE) begin
               // Counter parks at zero so it never runs past the top lane.
               carry_out_d = add_cout;
               byte_cnt_d  = '0;
               state_d     = ST_DONE;
            end else begin
               byte_cnt_d = byte_cnt_q + 1'b1;
            end
         end

         ST_DONE: begin
            // Single-cycle completion pulse; any start seen here is dropped, not queued.
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign result    = result_q;
   assign carry_out = carry_out_q;

endmodule

// File: tb/tb_seed_add32_seq.sv
// Testbench for seed_add32_seq (WORD_BYTES=4) paired with a behavioural 8-bit adder.
// Build with +define+SEED_ADDSEQ_SUB_EN to exercise the subtract path.
module tb_seed_add32_seq;

   localparam int WB = 4;
   localparam int W  = 8 * WB;
`ifdef SEED_ADDSEQ_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          op_sub;
   logic [W-1:0]  a_in;
   logic [W-1:0]  b_in;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          carry_out;
   logic [7:0]    add_a;
   logic [7:0]    add_b;
   logic          add_cin;
   logic [7:0]    add_sum;
   logic          add_cout;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // External ripple adder, combinational.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

   seed_add32_seq #(.WORD_BYTES(WB)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op_sub    (op_sub),
      .a_in      (a_in),
      .b_in      (b_in),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_sum   (add_sum),
      .add_cout  (add_cout)
   );

   // Reference: {carry, value} of the word-level operation.
   function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      logic eff_sub;
      eff_sub = sub & SUB_EN;
      if (eff_sub) return {(a >= b), a - b};
      return {1'b0, a} + {1'b0, b};
   endfunction

   // Launch one op from IDLE and wait for done; returns observed values.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output logic [W-1:0] res, output logic cout, output int lat,
                         output logic [7:0] cin_trace, output logic busy_after, output logic done_after);
      a_in = a; b_in = b; op_sub = sub; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a_in = $urandom; b_in = $urandom; op_sub = ~sub;
      lat = 0;
      cin_trace = 8'h00;
      while (!done && lat < 20) begin
         if (lat < 8) cin_trace[lat] = add_cin;
         @(posedge clk); #1;
         lat++;
      end
      res  = result;
      cout = carry_out;
      @(posedge clk); #1;
      busy_after = busy;
      done_after = done;
      $display("op a=%08h b=%08h sub=%0b -> result=%08h carry_out=%0b latency=%0d", a, b, sub, res, cout, lat);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; op_sub = 1'b0;
      a_in = $urandom; b_in = $urandom;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if ({busy, done, carry_out} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags busy/done/carry_out=%03b required=000", {busy, done, carry_out});
      end
      checks++;
      if (result !== '0) begin
         failures++;
         $display("FAIL reset_result got=%08h required=00000000", result);
      end
      checks++;
      if ({add_a, add_b, add_cin} !== 17'd0) begin
         failures++;
         $display("FAIL reset_adder_drive a=%02h b=%02h cin=%0b required 0", add_a, add_b, add_cin);
      end
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle busy=%0b required=0", busy);
      end
      $display("reset sequence complete");
   endtask

   task automatic test_directed_add();
      logic [W-1:0] res; logic cout; int lat; logic [7:0] tr; logic ba, da;
      run_op(32'h89ABCDEF, 32'h76543211, 1'b0, res, cout, lat, tr, ba, da);
      checks++;
      if ({cout, res} !== 33'h1_0000_0000) begin
         failures++;
         $display("FAIL add_wrap got=%0b_%08h required=1_00000000", cout, res);
      end
      checks++;
      if (lat !== WB) begin
         failures++;
         $display("FAIL add_latency got=%0d required=%0d", lat, WB);
      end
      checks++;
      if ({ba, da} !== 2'b00) begin
         failures++;
         $display("FAIL done_pulse busy/done after=%02b required=00", {ba, da});
      end
      checks++;
      if ({add_a, add_b, add_cin} !== 17'd0) begin
         failures++;
         $display("FAIL idle_adder_drive a=%02h b=%02h cin=%0b required 0", add_a, add_b, add_cin);
      end
      run_op(32'h000000FF, 32'h00000001, 1'b0, res, cout, lat, tr, ba, da);
      checks++;
      if ({cout, res} !== 33'h0_0000_0100) begin
         failures++;
         $display("FAIL add_carry_byte got=%0b_%08h required=0_00000100", cout, res);
      end
      checks++;
      if (tr[WB-1:0] !== 4'b0010) begin
         failures++;
         $display("FAIL cin_trace got=%04b required=0010", tr[WB-1:0]);
      end
   endtask

`ifdef SEED_ADDSEQ_SUB_EN
   task automatic test_sub();
      logic [W-1:0] res; logic cout; int lat; logic [7:0] tr; logic ba, da;
      run_op(32'h00000000, 32'h00000001, 1'b1, res, cout, lat, tr, ba, da);
      checks++;
      if ({cout, res} !== 33'h0_FFFF_FFFF) begin
         failures++;
         $display("FAIL sub_borrow got=%0b_%08h required=0_ffffffff", cout, res);
      end
      checks++;
      if (tr[0] !== 1'b1) begin
         failures++;
         $display("FAIL sub_init_cin got=%0b required=1", tr[0]);
      end
      run_op(32'h12345678, 32'h12345678, 1'b1, res, cout, lat, tr, ba, da);
      checks++;
      if ({cout, res} !== 33'h1_0000_0000) begin
         failures++;
         $display("FAIL sub_equal got=%0b_%08h required=1_00000000", cout, res);
      end
   endtask
`else
   task automatic test_add_only();
      logic [W-1:0] res; logic cout; int lat; logic [7:0] tr; logic ba, da;
      run_op(32'd5, 32'd3, 1'b1, res, cout, lat, tr, ba, da);
      checks++;
      if ({cout, res} !== 33'd8) begin
         failures++;
         $display("FAIL add_only_opsub got=%0b_%08h required=0_00000008", cout, res);
      end
   endtask
`endif

   task automatic test_random();
      logic [W-1:0] a, b, res; logic s, cout; int lat; logic [7:0] tr; logic ba, da;
      logic [W:0] exp;
      for (int i = 0; i < 24; i++) begin
         a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
         if (i == 0) begin a = '1; b = '1; end
         run_op(a, b, s, res, cout, lat, tr, ba, da);
         exp = ref_op(a, b, s);
         checks++;
         if ({cout, res} !== exp || lat !== WB) begin
            failures++;
            $display("FAIL random_op[%0d] got=%0b_%08h lat=%0d required=%0b_%08h lat=%0d",
                     i, cout, res, lat, exp[W], exp[W-1:0], lat, WB);
         end
      end
   endtask

   task automatic test_back_to_back();
      int phase = 0;
      int dones = 0;
      logic [W:0] exp_q[$];
      logic [W:0] e;
      logic [W-1:0] ca, cb; logic cs, exp_done;
      for (int cyc = 0; cyc < 24; cyc++) begin
         ca = $urandom; cb = $urandom; cs = 1'($urandom_range(0, 1));
         a_in = ca; b_in = cb; op_sub = cs; start = (cyc < 14);
         @(posedge clk); #1;
         if (phase == 0) begin
            if (start) begin
               exp_q.push_back(ref_op(ca, cb, cs));
               phase = 1;
            end
         end else if (phase == WB + 1) begin
            phase = 0;
         end else begin
            phase++;
         end
         exp_done = (phase == WB + 1);
         checks++;
         if (done !== exp_done) begin
            failures++;
            $display("FAIL b2b_done_cycle[%0d] got=%0b required=%0b", cyc, done, exp_done);
         end
         if (done === 1'b1) begin
            dones++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL b2b_extra_done cycle=%0d got=done required=no done", cyc);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if ({carry_out, result} !== e) begin
                  failures++;
                  $display("FAIL b2b_result got=%0b_%08h required=%0b_%08h", carry_out, result, e[W], e[W-1:0]);
               end
               $display("b2b op complete cycle=%0d result=%08h carry_out=%0b", cyc, result, carry_out);
            end
         end
      end
      start = 1'b0;
      checks++;
      if (dones !== 3) begin
         failures++;
         $display("FAIL b2b_done_count got=%0d required=3", dones);
      end
   endtask

   task automatic test_reset_midop();
      int seen_done = 0;
      logic [W-1:0] a, b, res; logic cout; int lat; logic [7:0] tr; logic ba, da;
      logic [W:0] exp;
      a_in = $urandom; b_in = $urandom; op_sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;      // RUN byte 0
      start = 1'b0;
      @(posedge clk); #1;      // RUN byte 1
      @(posedge clk); #1;      // RUN byte 2
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({busy, done, carry_out} !== 3'b000 || result !== '0) begin
         failures++;
         $display("FAIL midop_reset busy/done/cout=%03b result=%08h required=000 00000000",
                  {busy, done, carry_out}, result);
      end
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen_done++;
      end
      checks++;
      if (seen_done !== 0) begin
         failures++;
         $display("FAIL midop_no_done got=%0d done pulses required=0", seen_done);
      end
      $display("reset mid-operation complete");
      a = $urandom; b = $urandom;
      run_op(a, b, 1'b0, res, cout, lat, tr, ba, da);
      exp = ref_op(a, b, 1'b0);
      checks++;
      if ({cout, res} !== exp) begin
         failures++;
         $display("FAIL midop_recover got=%0b_%08h required=%0b_%08h", cout, res, exp[W], exp[W-1:0]);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op_sub = 1'b0; a_in = '0; b_in = '0;
      test_reset();
      test_directed_add();
`ifdef SEED_ADDSEQ_SUB_EN
      test_sub();
`else
      test_add_only();
`endif
      test_random();
      test_back_to_back();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout simulation time exceeded limit");
      $fatal(1, "timeout");
   end

endmodule
